// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle ALU with an iterative signed multiplier and an
// optional iterative signed divider sharing one control FSM.
// Build option: define ALU_MULDIV_DIV_EN to include the restoring divider;
// without it DIV (op 11) behaves as a reserved single-cycle opcode.
module alu_muldiv #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   data1,
    input  logic [WIDTH-1:0]   data2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   result,
    output logic               overflow,
    output logic               zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
        OP_SLL  = 4'd4,  OP_SRL  = 4'd5,  OP_SRA  = 4'd6,  OP_SGT  = 4'd7,
        OP_SLT  = 4'd8,  OP_NOR  = 4'd9,  OP_MULT = 4'd10, OP_DIV  = 4'd11,
        OP_MFHI = 4'd12, OP_MFLO = 4'd13
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    // Shared iteration register: MULT holds {partial product, multiplier},
    // DIV holds {remainder, dividend/quotient}.
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 neg_q, neg_d;
    logic                 eq_q, eq_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 overflow_q, overflow_d;
    logic                 zero_q, zero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 accept;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     addend, sum, alu_res;
    logic                 alu_ovf;

`ifdef ALU_MULDIV_DIV_EN
    logic                 is_div_q, is_div_d;
    logic                 rsgn_q, rsgn_d;
    logic                 dz_q, dz_d;
    logic                 mn_q, mn_d;
    logic [WIDTH-1:0]     op1_q, op1_d;
    logic [WIDTH:0]       div_sh, div_diff;
    logic                 div_ge;
    logic [WIDTH-1:0]     quo, rem;

    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, mcand_q};
    assign div_ge   = (div_sh >= {1'b0, mcand_q});
    assign quo      = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign rem      = rsgn_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
`endif

    assign accept    = in_valid && (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign in_ready  = ~busy;
    assign mag1      = data1[WIDTH-1] ? (~data1 + 1'b1) : data1;
    assign mag2      = data2[WIDTH-1] ? (~data2 + 1'b1) : data2;
    assign mul_sum   = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
    assign prod      = neg_q ? (~acc_q[2*WIDTH-1:0] + 1'b1) : acc_q[2*WIDTH-1:0];

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    // Single-cycle ALU result and ADD/SUB overflow from the presented operands
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        addend  = (op == OP_SUB) ? (~data2 + 1'b1) : data2;
        sum     = data1 + addend;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res = sum;
                alu_ovf = (data1[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_AND:  alu_res = data1 & data2;
            OP_OR:   alu_res = data1 | data2;
            OP_SLL:  alu_res = data1 << shamt;
            OP_SRL:  alu_res = data1 >> shamt;
            OP_SRA:  alu_res = $signed(data1) >>> shamt;
            OP_SGT:  alu_res = WIDTH'($signed(data1) > $signed(data2));
            OP_SLT:  alu_res = WIDTH'($signed(data1) < $signed(data2));
            OP_NOR:  alu_res = ~(data1 | data2);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // Next-state, iteration datapath and registered-output update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        neg_d       = neg_q;
        eq_d        = eq_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
`ifdef ALU_MULDIV_DIV_EN
        is_div_d    = is_div_q;
        rsgn_d      = rsgn_q;
        dz_d        = dz_q;
        mn_d        = mn_q;
        op1_d       = op1_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    eq_d  = (data1 == data2);
                    cnt_d = '0;
                    neg_d = data1[WIDTH-1] ^ data2[WIDTH-1];
`ifdef ALU_MULDIV_DIV_EN
                    is_div_d = (op == OP_DIV);
`endif
                    if (op == OP_MULT) begin
                        state_d = S_MUL;
                        acc_d   = {{(WIDTH+1){1'b0}}, mag2};
                        mcand_d = mag1;
                    end
`ifdef ALU_MULDIV_DIV_EN
                    else if (op == OP_DIV) begin
                        state_d = S_DIV;
                        acc_d   = {{(WIDTH+1){1'b0}}, mag1};
                        mcand_d = mag2;
                        rsgn_d  = data1[WIDTH-1];
                        dz_d    = (data2 == '0);
                        mn_d    = (data1 == {1'b1, {(WIDTH-1){1'b0}}}) && (data2 == '1);
                        op1_d   = data1;
                    end
`endif
                    else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        overflow_d  = alu_ovf;
                        zero_d      = (data1 == data2);
                    end
                end
            end
            S_MUL: begin
                // Add multiplicand into the upper half on a set LSB, then shift right.
                acc_d = {1'b0, (acc_q[0] ? mul_sum : acc_q[2*WIDTH:WIDTH]), acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = S_DONE;
            end
`ifdef ALU_MULDIV_DIV_EN
            S_DIV: begin
                acc_d = {(div_ge ? div_diff : div_sh), acc_q[WIDTH-2:0], div_ge};
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = S_DONE;
            end
`endif
            S_DONE: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b1;
                zero_d      = eq_q;
                overflow_d  = 1'b0;
                hi_d        = prod[2*WIDTH-1:WIDTH];
                lo_d        = prod[WIDTH-1:0];
                result_d    = prod[WIDTH-1:0];
`ifdef ALU_MULDIV_DIV_EN
                if (is_div_q) begin
                    if (dz_q) begin
                        hi_d       = op1_q;
                        lo_d       = '1;
                        result_d   = '1;
                        overflow_d = 1'b1;
                    end else begin
                        hi_d       = rem;
                        lo_d       = quo;
                        result_d   = quo;
                        overflow_d = mn_q;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            neg_q       <= 1'b0;
            eq_q        <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
`ifdef ALU_MULDIV_DIV_EN
            is_div_q    <= 1'b0;
            rsgn_q      <= 1'b0;
            dz_q        <= 1'b0;
            mn_q        <= 1'b0;
            op1_q       <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            neg_q       <= neg_d;
            eq_q        <= eq_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
`ifdef ALU_MULDIV_DIV_EN
            is_div_q    <= is_div_d;
            rsgn_q      <= rsgn_d;
            dz_q        <= dz_d;
            mn_q        <= mn_d;
            op1_q       <= op1_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): directed corner cases plus
// randomized single-cycle ops against a behavioural arithmetic model.
module tb_alu_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic [W-1:0]  data1, data2;
    logic [4:0]    shamt;
    logic          out_valid;
    logic [W-1:0]  result;
    logic          overflow, zero;
    logic [W-1:0]  hi, lo;
    logic          busy;

    int checks = 0;
    int failures = 0;

    // Architectural HI/LO as the model expects them
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    alu_muldiv #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .data1(data1), .data2(data2), .shamt(shamt), .out_valid(out_valid),
        .result(result), .overflow(overflow), .zero(zero), .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model of the single-cycle operations
    function automatic void ref_single(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] s, output logic [31:0] r, output logic v);
        longint t;
        logic [31:0] nb;
        r  = '0;
        v  = 1'b0;
        nb = 32'd0 - b;
        case (o)
            4'd0: begin
                t = longint'($signed(a)) + longint'($signed(b));
                r = t[31:0];
                v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd1: begin
                t = longint'($signed(a)) + longint'($signed(nb));
                r = t[31:0];
                v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a << s;
            4'd5:  r = a >> s;
            4'd6:  r = $signed(a) >>> s;
            4'd7:  r = ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  r = ~(a | b);
            4'd12: r = m_hi;
            4'd13: r = m_lo;
            default: r = '0;
        endcase
    endfunction

    function automatic logic [31:0] pick_val();
        logic [31:0] c [5];
        c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'h7FFFFFFF; c[3] = 32'h80000000; c[4] = 32'hFFFFFFFF;
        if ($urandom_range(0, 2) == 0) return c[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; op = 4'd0; data1 = 32'd3; data2 = 32'd3; shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
        checks++; if ({overflow, zero} !== 2'b00) begin failures++; $display("FAIL reset_flags: got %b expected 00", {overflow, zero}); end
        checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
        checks++; if ({busy, in_ready} !== 2'b01) begin failures++; $display("FAIL reset_busy_ready: got %b expected 01", {busy, in_ready}); end
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_discard: got out_valid %b expected 0", out_valid); end
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_add_overflow();
        @(negedge clk); op = 4'd0; data1 = 32'h7FFFFFFF; data2 = 32'h1; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid: got %b expected 1", out_valid); end
        checks++; if (result !== 32'h80000000) begin failures++; $display("FAIL add_result: got %h expected 80000000", result); end
        checks++; if ({overflow, zero} !== 2'b10) begin failures++; $display("FAIL add_flags: got %b expected 10", {overflow, zero}); end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_pulse: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); op = 4'd1; data1 = 32'd5; data2 = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if ({out_valid, result, zero, overflow} !== {1'b1, 32'h0, 1'b1, 1'b0})
            begin failures++; $display("FAIL b2b_sub: got v=%b r=%h z=%b o=%b expected v=1 r=0 z=1 o=0", out_valid, result, zero, overflow); end
        @(negedge clk); op = 4'd6; data1 = 32'h80000000; data2 = 32'h0; shamt = 5'd4;
        @(posedge clk); #1;
        checks++; if ({out_valid, result, zero} !== {1'b1, 32'hF8000000, 1'b0})
            begin failures++; $display("FAIL b2b_sra: got v=%b r=%h z=%b expected v=1 r=f8000000 z=0", out_valid, result, zero); end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_pulse: got %b expected 0", out_valid); end
    endtask

    task automatic test_random_alu();
        logic [31:0] e_r;
        logic        e_v;
        logic [3:0]  o;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            do o = 4'($urandom_range(0, 15));
`ifdef ALU_MULDIV_DIV_EN
            while (o == 4'd10 || o == 4'd11);
`else
            while (o == 4'd10);
`endif
            op = o; data1 = pick_val();
            data2 = ($urandom_range(0, 3) == 0) ? data1 : pick_val();
            shamt = 5'($urandom_range(0, 31)); in_valid = 1'b1;
            ref_single(o, data1, data2, shamt, e_r, e_v);
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rnd_valid op=%0d: got %b expected 1", o, out_valid); end
            checks++; if (result !== e_r) begin failures++; $display("FAIL rnd_result op=%0d a=%h b=%h s=%0d: got %h expected %h", o, data1, data2, shamt, result, e_r); end
            checks++; if (overflow !== e_v) begin failures++; $display("FAIL rnd_overflow op=%0d a=%h b=%h: got %b expected %b", o, data1, data2, overflow, e_v); end
            checks++; if (zero !== (data1 == data2)) begin failures++; $display("FAIL rnd_zero op=%0d: got %b expected %b", o, zero, data1 == data2); end
            checks++; if ({hi, lo, in_ready} !== {m_hi, m_lo, 1'b1}) begin failures++; $display("FAIL rnd_hilo_ready: got %h %h %b expected %h %h 1", hi, lo, in_ready, m_hi, m_lo); end
        end
        @(negedge clk); in_valid = 1'b0;
    endtask

    task automatic test_mult();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [63:0] p;
        int n, busyc;
        bit moved;
        va = '{32'd6, 32'h80000000, 32'h80000000, 32'd0, $urandom(), 32'hFFFFFFFD};
        vb = '{32'd715827883, 32'h80000000, 32'hFFFFFFFF, $urandom(), $urandom(), 32'd7};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); op = 4'd10; data1 = va[i]; data2 = vb[i]; in_valid = 1'b1;
            p = 64'(longint'($signed(va[i])) * longint'($signed(vb[i])));
            @(posedge clk); #1;
            n = 0; busyc = 0; moved = 1'b0;
            while (out_valid !== 1'b1 && n < 80) begin
                if (in_ready === 1'b0) busyc++;
                if (hi !== m_hi || lo !== m_lo) moved = 1'b1;
                @(negedge clk); op = 4'd0; data1 = $urandom(); data2 = $urandom(); in_valid = (n < 20);
                @(posedge clk); #1;
                n++;
            end
            checks++; if (n != 33) begin failures++; $display("FAIL mult_latency %0d: got %0d expected 33", i, n); end
            checks++; if (busyc != 33) begin failures++; $display("FAIL mult_busy %0d: got %0d expected 33", i, busyc); end
            checks++; if (moved) begin failures++; $display("FAIL mult_hilo_hold %0d: got early change expected none", i); end
            checks++; if ({hi, lo} !== p) begin failures++; $display("FAIL mult_hilo %0d %h*%h: got %h expected %h", i, va[i], vb[i], {hi, lo}, p); end
            checks++; if (result !== p[31:0]) begin failures++; $display("FAIL mult_result %0d: got %h expected %h", i, result, p[31:0]); end
            checks++; if ({overflow, zero, in_ready} !== {1'b0, va[i] == vb[i], 1'b1})
                begin failures++; $display("FAIL mult_flags %0d: got %b expected %b", i, {overflow, zero, in_ready}, {1'b0, va[i] == vb[i], 1'b1}); end
            m_hi = p[63:32]; m_lo = p[31:0];
            @(negedge clk); in_valid = 1'b0;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mult_pulse %0d: got %b expected 0", i, out_valid); end
        end
        @(negedge clk); op = 4'd12; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (result !== m_hi) begin failures++; $display("FAIL mfhi: got %h expected %h", result, m_hi); end
        @(negedge clk); op = 4'd13;
        @(posedge clk); #1;
        checks++; if (result !== m_lo) begin failures++; $display("FAIL mflo: got %h expected %h", result, m_lo); end
        @(negedge clk); in_valid = 1'b0;
    endtask

`ifdef ALU_MULDIV_DIV_EN
    task automatic test_div();
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic [31:0] e_hi, e_lo;
        logic        e_v;
        int n, qa, ra;
        va = '{32'hFFFFFFF9, 32'd9, 32'h80000000, 32'd100, 32'hFFFFFF9C, $urandom(), $urandom()};
        vb = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, $urandom() | 32'h1, 32'd3};
        for (int i = 0; i < 7; i++) begin
            if (vb[i] == 32'd0) begin
                e_lo = '1; e_hi = va[i]; e_v = 1'b1;
            end else if (va[i] == 32'h80000000 && vb[i] == 32'hFFFFFFFF) begin
                e_lo = 32'h80000000; e_hi = '0; e_v = 1'b1;
            end else begin
                qa = int'($signed(va[i])) / int'($signed(vb[i]));
                ra = int'($signed(va[i])) % int'($signed(vb[i]));
                e_lo = qa; e_hi = ra; e_v = 1'b0;
            end
            @(negedge clk); op = 4'd11; data1 = va[i]; data2 = vb[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            n = 0;
            while (out_valid !== 1'b1 && n < 80) begin
                @(negedge clk); data1 = $urandom(); data2 = $urandom(); in_valid = 1'b0;
                @(posedge clk); #1;
                n++;
            end
            checks++; if (n != 33) begin failures++; $display("FAIL div_latency %0d: got %0d expected 33", i, n); end
            checks++; if ({hi, lo} !== {e_hi, e_lo}) begin failures++; $display("FAIL div_hilo %0d %h/%h: got %h %h expected %h %h", i, va[i], vb[i], hi, lo, e_hi, e_lo); end
            checks++; if ({result, overflow} !== {e_lo, e_v}) begin failures++; $display("FAIL div_result %0d: got %h %b expected %h %b", i, result, overflow, e_lo, e_v); end
            m_hi = e_hi; m_lo = e_lo;
        end
    endtask
`else
    task automatic test_div_disabled();
        @(negedge clk); op = 4'd11; data1 = 32'd8; data2 = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if ({out_valid, result, overflow, zero} !== {1'b1, 32'h0, 1'b0, 1'b0})
            begin failures++; $display("FAIL divoff_result: got v=%b r=%h o=%b z=%b expected v=1 r=0 o=0 z=0", out_valid, result, overflow, zero); end
        checks++; if ({hi, lo, busy, in_ready} !== {m_hi, m_lo, 1'b0, 1'b1})
            begin failures++; $display("FAIL divoff_hilo: got %h %h %b %b expected %h %h 0 1", hi, lo, busy, in_ready, m_hi, m_lo); end
        @(negedge clk); in_valid = 1'b0;
    endtask
`endif

    task automatic test_reset_abort();
        int n, pulses;
        // Load hi/lo = 1/2 via 6 * 715827883 = 2**32 + 2
        @(negedge clk); op = 4'd10; data1 = 32'd6; data2 = 32'd715827883; in_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 80) begin @(posedge clk); #1; n++; end
        checks++; if ({hi, lo} !== {32'h1, 32'h2}) begin failures++; $display("FAIL abort_setup: got %h %h expected 1 2", hi, lo); end
        @(negedge clk); op = 4'd10; data1 = 32'hFFFFFFFD; data2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); rst = 1'b1; op = 4'd0; data1 = 32'd1; data2 = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if ({busy, in_ready, out_valid} !== 3'b010) begin failures++; $display("FAIL abort_state: got %b expected 010", {busy, in_ready, out_valid}); end
        checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL abort_hilo: got %h expected 0", {hi, lo}); end
        m_hi = '0; m_lo = '0;
        @(negedge clk); rst = 1'b0; op = 4'd0; data1 = 32'd2; data2 = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if ({out_valid, result} !== {1'b1, 32'd5}) begin failures++; $display("FAIL abort_add: got %b %h expected 1 5", out_valid, result); end
        @(negedge clk); in_valid = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL abort_no_result: got %0d pulses expected 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_mult();
`ifdef ALU_MULDIV_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_random_alu();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width, even, minimum 8.
REQ-002 Parameter SHAMT_W, default 5: shift-amount width; SHALL satisfy 2**SHAMT_W == WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept; SHALL equal ~busy.
REQ-007 op  input  4  operation code.
REQ-008 data1, data2  input  WIDTH each  signed operands.
REQ-009 shamt  input  SHAMT_W  shift amount.
REQ-010 out_valid  output  1  one-cycle pulse: result, overflow and zero are valid.
REQ-011 result  output  WIDTH  registered signed result.
REQ-012 overflow, zero  output  1 each  registered flags.
REQ-013 hi, lo  output  WIDTH each  architectural HI/LO registers.
REQ-014 busy  output  1  multi-cycle operation in progress.

Function
REQ-015 Accept when in_valid & in_ready on a rising edge; no output back-pressure.
REQ-016 Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SRA, 7 SGT, 8 SLT, 9 NOR, 10 MULT, 11 DIV, 12 MFHI, 13 MFLO, 14-15 reserved.
REQ-017 Ops 0-9 and 12-13: result and out_valid registered the cycle after acceptance (latency 1); back-to-back acceptance every cycle.
REQ-018 ADD/SUB overflow SHALL be computed from the sum produced in the same operation: operands (data2 negated for SUB, two's-complement) same sign and sum sign differs; overflow 0 for all other single-cycle ops.
REQ-019 zero SHALL be 1 iff data1 == data2 for every accepted op, registered with result.
REQ-020 SGT/SLT: signed compare, result 1 or 0 zero-extended; shifts use shamt, SRA sign-fills.
REQ-021 MFHI/MFLO: result = hi/lo as held at acceptance.
REQ-022 Reserved ops: result 0, overflow 0, out_valid pulses, latency 1.
REQ-023 FSM states IDLE, MUL, DIV, DONE; IDLE->MUL on MULT accept, IDLE->DIV on DIV accept, MUL/DIV->DONE after WIDTH iteration cycles, DONE->IDLE next cycle.
REQ-024 busy = 1 in MUL, DIV, DONE; in_ready = 0 there.
REQ-025 MULT: signed WIDTH x WIDTH iterative shift-add, one bit per cycle; {hi,lo} = 2*WIDTH-bit product; out_valid and hi/lo update in DONE, i.e. WIDTH+1 cycles after acceptance; result = lo; overflow = 0.
REQ-026 DIV: signed restoring, one quotient bit per cycle; lo = quotient truncated toward zero, hi = remainder with sign of data1; same latency as MULT; result = lo.
REQ-027 DIV by zero: lo = all ones, hi = data1, overflow = 1.
REQ-028 DIV of most-negative by -1: lo = most-negative, hi = 0, overflow = 1.
REQ-029 hi/lo SHALL change only in DONE; operand values are captured at acceptance, later input changes ignored.

Reset
REQ-030 rst SHALL force IDLE, out_valid, result, overflow, zero, hi, lo, busy to 0 and in_ready to 1 on the next edge, aborting any MUL/DIV in progress without updating hi/lo.
REQ-031 A request presented in the reset cycle SHALL be discarded.

Configuration
REQ-032 Macro ALU_MULDIV_DIV_EN: defined -> DIV per REQ-026..028; undefined -> no divider logic, DIV treated as reserved (REQ-022), DIV state unreachable, hi/lo unchanged.

Verification
REQ-033 ADD 0x7FFFFFFF + 0x00000001 -> next cycle result 0x80000000, overflow 1, zero 0, out_valid 1 for one cycle.
REQ-034 SUB 5 - 5, then SRA 0x80000000 by 4 on consecutive cycles -> results 0 with zero 1, then 0xF8000000; two consecutive out_valid pulses.
REQ-035 MULT -3 x 7 -> in_ready low 33 cycles, out_valid at cycle 33, hi 0xFFFFFFFF, lo 0xFFFFFFEB; then MFHI -> result 0xFFFFFFFF.
REQ-036 DIV -7 / 2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF; DIV 9 / 0 -> lo 0xFFFFFFFF, hi 9, overflow 1; DIV 0x80000000 / -1 -> lo 0x80000000, hi 0, overflow 1.
REQ-037 Assert rst at cycle 10 of a MULT with hi/lo = 0x1/0x2 -> next edge busy 0, hi 0, lo 0, no out_valid; new ADD accepted immediately after.
REQ-038 Build without ALU_MULDIV_DIV_EN, issue DIV 8 / 2 -> latency 1, result 0, overflow 0, hi/lo unchanged.
